// File: rtl/matrix_pkg.sv
// Shared matrix sizes and types for the receive and transmit paths.
package matrix_pkg;

  localparam int unsigned MAX_ELEMENT_SIZE = 8;
  localparam int unsigned MAX_SIZE         = 32;
  localparam int unsigned ROW_W            = MAX_SIZE * MAX_ELEMENT_SIZE;
  localparam int unsigned DPR              = ROW_W / 2;
  localparam int unsigned DIBIT_CNT_W      = $clog2(DPR);
  localparam int unsigned ROW_CNT_W        = $clog2(MAX_SIZE);
  localparam int unsigned CSUM_W           = 16;
  localparam int unsigned CSUM_DIBITS      = CSUM_W / 2;
  localparam int unsigned CSUM_CNT_W       = $clog2(CSUM_DIBITS);

  typedef logic [1:0]       dibit_t;
  typedef logic [ROW_W-1:0] row_t;

  typedef enum logic [1:0] {IDLE, SEND, STALL, CSUM} tx_state_t;

  // Unsigned sum of every element in a row, wrapped to the checksum width.
  function automatic logic [CSUM_W-1:0] row_sum(input row_t row);
    logic [CSUM_W-1:0] acc;
    acc = '0;
    for (int k = 0; k < int'(MAX_SIZE); k++)
      acc = acc + CSUM_W'(row[ROW_W-1-k*MAX_ELEMENT_SIZE -: MAX_ELEMENT_SIZE]);
    return acc;
  endfunction

endpackage

// File: rtl/row_serializer.sv
// Row shift register: presents one dibit per shift, MSB dibit first, and flags the last one.
module row_serializer
  import matrix_pkg::*;
(
  input  logic   eth_refclk,
  input  logic   rst,
  input  logic   load,
  input  row_t   load_data,
  input  logic   shift_en,
  output dibit_t dibit,
  output logic   last
);

  row_t                   shreg;
  logic [DIBIT_CNT_W-1:0] dibit_cnt;

  // Load wins over shift so a new row can replace the last dibit seamlessly.
  always_ff @(posedge eth_refclk) begin
    if (rst) begin
      shreg     <= '0;
      dibit_cnt <= '0;
    end else if (load) begin
      shreg     <= load_data;
      dibit_cnt <= '0;
    end else if (shift_en) begin
      shreg     <= {shreg[ROW_W-3:0], 2'b00};
      dibit_cnt <= dibit_cnt + DIBIT_CNT_W'(1);
    end
  end

  assign dibit = shreg[ROW_W-1 -: 2];
  assign last  = (dibit_cnt == DIBIT_CNT_W'(DPR - 1));

endmodule

// File: rtl/matrix_transmitter.sv
// Result-row to dibit stream serializer with one pending row of buffering.
// Optional trailing 16-bit element checksum when MATRIX_TX_CHECKSUM_EN is defined.
module matrix_transmitter
  import matrix_pkg::*;
(
  input  logic   eth_refclk,
  input  logic   rst,
  input  logic   row_valid,
  input  row_t   row_data,
  output logic   row_ready,
  output logic   axiov,
  output dibit_t axiod,
  output logic   busy,
  output logic   underrun,
  output logic   complete
);

  tx_state_t            state;
  logic                 pend_valid;
  logic                 pend_valid_nxt;
  row_t                 pend_data;
  logic [ROW_CNT_W-1:0] row_cnt;
  logic                 last_row;
  logic                 row_end;
  logic                 load_row;
  logic                 load;
  logic                 shift_en;
  logic                 last;
  row_t                 load_data;

  // row_cnt is the row on the wire while in SEND, the next row otherwise.
  assign last_row       = (row_cnt == ROW_CNT_W'(MAX_SIZE - 1));
  assign row_end        = (state == SEND) && last;
  assign load_row       = pend_valid &&
                          ((state == IDLE) || (state == STALL) || (row_end && !last_row));
  assign pend_valid_nxt = (pend_valid && !load_row) || (row_valid && row_ready);

`ifdef MATRIX_TX_CHECKSUM_EN
  logic [CSUM_W-1:0]     csum;
  logic [CSUM_CNT_W-1:0] csum_cnt;
  logic                  load_csum;

  // The checksum rides out through the shifter's top bits after the final row.
  assign load_csum = row_end && last_row;
  assign load      = load_row || load_csum;
  assign load_data = load_csum ? {csum, {(ROW_W-CSUM_W){1'b0}}} : pend_data;
  assign shift_en  = (state == SEND) || (state == CSUM);

  always_ff @(posedge eth_refclk) begin
    if (rst) begin
      csum     <= '0;
      csum_cnt <= '0;
    end else begin
      if (load_row)
        csum <= (state == IDLE) ? row_sum(pend_data) : csum + row_sum(pend_data);
      if (load_csum)
        csum_cnt <= '0;
      else if (state == CSUM)
        csum_cnt <= csum_cnt + CSUM_CNT_W'(1);
    end
  end
`else
  assign load      = load_row;
  assign load_data = pend_data;
  assign shift_en  = (state == SEND);
`endif

  row_serializer u_ser (
    .eth_refclk (eth_refclk),
    .rst        (rst),
    .load       (load),
    .load_data  (load_data),
    .shift_en   (shift_en),
    .dibit      (axiod),
    .last       (last)
  );

  always_ff @(posedge eth_refclk) begin
    if (rst) begin
      state      <= IDLE;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      row_cnt    <= '0;
      row_ready  <= 1'b0;
      axiov      <= 1'b0;
      busy       <= 1'b0;
      underrun   <= 1'b0;
      complete   <= 1'b0;
    end else begin
      underrun   <= 1'b0;
      complete   <= 1'b0;
      pend_valid <= pend_valid_nxt;
      row_ready  <= !pend_valid_nxt;
      if (row_valid && row_ready)
        pend_data <= row_data;
      if (row_end)
        row_cnt <= row_cnt + ROW_CNT_W'(1);

      case (state)
        IDLE: if (pend_valid) begin
          state <= SEND;
          axiov <= 1'b1;
          busy  <= 1'b1;
        end
        SEND: if (last) begin
          if (last_row) begin
`ifdef MATRIX_TX_CHECKSUM_EN
            state <= CSUM;
`else
            state    <= IDLE;
            axiov    <= 1'b0;
            busy     <= 1'b0;
            complete <= 1'b1;
`endif
          end else if (!pend_valid) begin
            state    <= STALL;
            axiov    <= 1'b0;
            underrun <= 1'b1;
          end
        end
        STALL: if (pend_valid) begin
          state <= SEND;
          axiov <= 1'b1;
        end
`ifdef MATRIX_TX_CHECKSUM_EN
        CSUM: if (csum_cnt == CSUM_CNT_W'(CSUM_DIBITS - 1)) begin
          state    <= IDLE;
          axiov    <= 1'b0;
          busy     <= 1'b0;
          complete <= 1'b1;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
